// File: rtl/uart_pkg.sv
// Shared constants and parser state encoding for the UART command-frame path.
package uart_pkg;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam int unsigned CLK_HZ        = 12000000;
  localparam int unsigned BAUD          = 115200;
  localparam int unsigned TIMEOUT_DEF   = CLK_HZ / 1000;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

endpackage

// File: rtl/uart_frame_parser_buf.sv
// Payload store: one synchronous write port, one asynchronous read port.
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int IW    = 4,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Out-of-range reads return zero rather than aliasing into the array.
  always_comb begin
    rdata = '0;
    if (raddr < AW'(DEPTH)) rdata = mem_q[raddr[IW-1:0]];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SYNC/CMD/LEN/payload/CHK frames from a UART byte stream and holds
// a validated frame until the consumer acknowledges it.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = TIMEOUT_DEF,
  parameter int         LW           = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          frame_valid,
  output logic [7:0]    frame_cmd,
  output logic [LW-1:0] frame_len,
  input  logic [LW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  input  logic          frame_ack,
  output logic          err_chk,
  output logic          err_len,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam int            IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  state_t        state_q, state_d;
  logic          prev_vld_q, prev_vld_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    chk_q, chk_d;
  logic [LW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    frame_cmd_q, frame_cmd_d;
  logic [LW-1:0] frame_len_q, frame_len_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_to_q, err_to_d;
  logic          err_ovr_q, err_ovr_d;
  logic          accept;
  logic          busy;
  logic          we;

  assign accept = in_valid & ~prev_vld_q;
  assign busy   = (state_q == S_CMD) || (state_q == S_LEN) ||
                  (state_q == S_PAYLOAD) || (state_q == S_CHK);

  always_comb begin
    state_d     = state_q;
    prev_vld_d  = in_valid;
    cmd_d       = cmd_q;
    chk_d       = chk_q;
    len_d       = len_q;
    idx_d       = idx_q;
    tmo_d       = busy ? tmo_q + 1'b1 : '0;
    frame_cmd_d = frame_cmd_q;
    frame_len_d = frame_len_q;
    err_chk_d   = 1'b0;
    err_len_d   = 1'b0;
    err_to_d    = 1'b0;
    err_ovr_d   = 1'b0;
    we          = 1'b0;

    unique case (state_q)
      S_HUNT: begin
        if (accept && in_byte == SYNC_BYTE) state_d = S_CMD;
      end
      S_CMD: begin
        if (accept) begin
          cmd_d   = in_byte;
          chk_d   = in_byte;
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          len_d = in_byte[LW-1:0];
          chk_d = chk_q ^ in_byte;
          idx_d = '0;
          if (in_byte > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_HUNT;
          end else if (in_byte == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          we    = 1'b1;
          chk_d = chk_q ^ in_byte;
          idx_d = idx_q + 1'b1;
          if (LW'(idx_q) == len_q - 1'b1) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_byte == chk_q) begin
            state_d     = S_HOLD;
            frame_cmd_d = cmd_q;
            frame_len_d = len_q;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_HUNT;
          end
        end
      end
      S_HOLD: begin
        if (accept)    err_ovr_d = 1'b1;
        if (frame_ack) state_d   = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase

    // A byte landing on the last allowed idle clock keeps the frame alive.
    if (accept) begin
      tmo_d = '0;
    end else if (busy && tmo_q == TO_LAST) begin
      err_to_d = 1'b1;
      state_d  = S_HUNT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      prev_vld_q  <= 1'b1;
      cmd_q       <= '0;
      chk_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      frame_cmd_q <= '0;
      frame_len_q <= '0;
      err_chk_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_to_q    <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_vld_q  <= prev_vld_d;
      cmd_q       <= cmd_d;
      chk_q       <= chk_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      frame_cmd_q <= frame_cmd_d;
      frame_len_q <= frame_len_d;
      err_chk_q   <= err_chk_d;
      err_len_q   <= err_len_d;
      err_to_q    <= err_to_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  frame_buf #(
    .DEPTH (MAX_LEN),
    .IW    (IW),
    .AW    (LW)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (idx_q),
    .wdata (in_byte),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign frame_valid = (state_q == S_HOLD);
  assign frame_cmd   = frame_cmd_q;
  assign frame_len   = frame_len_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ovr_q;

endmodule
